// File: rtl/unidad_control_pila_if.sv
// Control-unit bus: instruction side (opcode, zero flag, PC+1) and the
// datapath control / return-stack status lines driven back by the unit.
interface unidad_control_pila_if #(
  parameter int OPW = 6,
  parameter int PCW = 10
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic [PCW-1:0] pc_next;
  logic           s_inc;
  logic           s_inm;
  logic           we3;
  logic           wez;
  logic [2:0]     Op;
  logic           pc_en;
  logic           s_pila;
  logic [PCW-1:0] dir_ret;
  logic           pila_vacia;
  logic           pila_llena;
  logic           error;

  modport master (
    output opcode, zero, pc_next,
    input  s_inc, s_inm, we3, wez, Op, pc_en, s_pila,
           dir_ret, pila_vacia, pila_llena, error
  );

  modport slave (
    input  opcode, zero, pc_next,
    output s_inc, s_inm, we3, wez, Op, pc_en, s_pila,
           dir_ret, pila_vacia, pila_llena, error
  );
endinterface

// File: rtl/unidad_control_pila.sv
// Control unit with call/return stack.
// Optional feature: define UC_PILA_EN to build the return stack (call/ret);
// without it, op4 1100/1101 decode as NOPs and no stack storage exists.
// Decode is combinational from op4/zero; only FSM state, error and the
// stack pointer/storage are registered.
module unidad_control_pila #(
  parameter int OPW   = 6,
  parameter int PCW   = 10,
  parameter int DEPTH = 4
) (
  input logic                   reloj,
  input logic                   reset,
  unidad_control_pila_if.slave  bus
);

  typedef enum logic [1:0] {ARRANQUE = 2'd0, EJEC = 2'd1, PARADO = 2'd2} estado_t;

  estado_t    estado;
  logic       error_q;
  logic       fallo;
  logic [3:0] op4;

  logic       s_inc, s_inm, we3, wez, pc_en, s_pila;
  logic [2:0] op_alu;

  assign op4 = bus.opcode[OPW-1:OPW-4];

`ifdef UC_PILA_EN
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_LLENO = SPW'(DEPTH);

  logic [SPW-1:0] sp;
  logic [PCW-1:0] entry [DEPTH];
  logic           es_call, es_ret, vacia, llena, push, pop;

  assign es_call = (estado == EJEC) && (op4 == 4'b1100);
  assign es_ret  = (estado == EJEC) && (op4 == 4'b1101);
  assign vacia   = (sp == '0);
  assign llena   = (sp == SP_LLENO);
  // Overflowing call or underflowing ret halts the machine instead of acting
  assign fallo   = (es_call && llena) || (es_ret && vacia);
  assign push    = es_call && !llena;
  assign pop     = es_ret && !vacia;

  // Stack pointer: async reset discards any push/pop pending on the edge
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset)    sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop)  sp <= sp - 1'b1;
  end

  // Stack storage; pop only moves sp, stale entries are left in place
  always_ff @(posedge reloj) begin
    if (push) entry[IW'(sp)] <= bus.pc_next;
  end

  assign bus.dir_ret    = vacia ? '0 : entry[IW'(sp - 1'b1)];
  assign bus.pila_vacia = vacia;
  assign bus.pila_llena = llena;
`else
  logic unused_pc;

  assign unused_pc      = ^bus.pc_next;
  assign fallo          = 1'b0;
  assign bus.dir_ret    = '0;
  assign bus.pila_vacia = 1'b1;
  assign bus.pila_llena = 1'b0;
`endif

  // Sequencer: one start-up cycle, then run until a stack fault parks it
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      estado  <= ARRANQUE;
      error_q <= 1'b0;
    end else begin
      case (estado)
        ARRANQUE: estado <= EJEC;
        EJEC: if (fallo) begin
          estado  <= PARADO;
          error_q <= 1'b1;
        end
        default:  estado <= PARADO;
      endcase
    end
  end

  // Instruction decode; outside EJEC everything idles with PC held
  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op_alu = 3'b000;
    pc_en  = 1'b0;
    s_pila = 1'b0;
    if (estado == EJEC) begin
      pc_en = !fallo;
      case (op4)
        4'b0000: begin s_inm = 1'b1; we3 = 1'b1; wez = 1'b1; end
        4'b0001: begin s_inm = 1'b1; op_alu = 3'b010; we3 = 1'b1; wez = 1'b1; end
        4'b0010: begin s_inm = 1'b1; op_alu = 3'b011; wez = 1'b1; end
        4'b0011: begin s_inm = 1'b1; op_alu = 3'b110; we3 = 1'b1; wez = 1'b1; end
        4'b0100, 4'b0101, 4'b0110, 4'b0111,
        4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
          op_alu = 3'(op4 - 4'd4);
          we3    = 1'b1;
          wez    = 1'b1;
        end
`ifdef UC_PILA_EN
        4'b1100: s_inc = 1'b0;
        4'b1101: begin s_inc = 1'b0; s_pila = 1'b1; end
`endif
        4'b1110: s_inc = ~bus.zero;
        4'b1111: s_inc = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.s_inc  = s_inc;
  assign bus.s_inm  = s_inm;
  assign bus.we3    = we3;
  assign bus.wez    = wez;
  assign bus.Op     = op_alu;
  assign bus.pc_en  = pc_en;
  assign bus.s_pila = s_pila;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_unidad_control_pila.sv
// Self-checking bench for unidad_control_pila. Reference model: run state,
// sticky error flag and a queue standing in for the return stack.
module tb_unidad_control_pila;
  localparam int OPW = 6, PCW = 10, DEPTH = 4;
`ifdef UC_PILA_EN
  localparam bit PILA = 1'b1;
`else
  localparam bit PILA = 1'b0;
`endif

  logic reloj, reset;
  int   errors = 0, checks = 0;

  unidad_control_pila_if #(.OPW(OPW), .PCW(PCW)) bus ();
  unidad_control_pila #(.OPW(OPW), .PCW(PCW), .DEPTH(DEPTH)) dut (
    .reloj(reloj), .reset(reset), .bus(bus)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // model: 0 = start-up, 1 = running, 2 = halted
  int             m_st;
  bit             m_err;
  logic [PCW-1:0] stk[$];
  int             cur_op;
  logic           cur_z;
  logic [PCW-1:0] cur_pc;

  function automatic void model_reset();
    m_st = 0; m_err = 1'b0; stk.delete();
  endfunction

  function automatic void model_edge(input int op, input logic [PCW-1:0] pcn);
    if (!reset) return;
    if (m_st == 0) m_st = 1;
    else if (m_st == 1 && PILA) begin
      if (op == 12) begin
        if (stk.size() == DEPTH) begin m_st = 2; m_err = 1'b1; end
        else stk.push_back(pcn);
      end else if (op == 13) begin
        if (stk.size() == 0) begin m_st = 2; m_err = 1'b1; end
        else void'(stk.pop_back());
      end
    end
  endfunction

  // {s_inc, s_inm, we3, wez, Op, pc_en, s_pila}
  function automatic logic [8:0] exp_ctrl(input int op, input logic z);
    logic si, sm, w, wz, pe, sp;
    logic [2:0] o;
    si = 1; sm = 0; w = 0; wz = 0; pe = 0; sp = 0; o = 0;
    if (m_st == 1) begin
      pe = 1;
      if (op == 0) begin sm = 1; w = 1; wz = 1; end
      else if (op <= 3) begin
        sm = 1; wz = 1; w = (op != 2);
        o = (op == 1) ? 3'd2 : (op == 2) ? 3'd3 : 3'd6;
      end
      else if (op <= 11) begin o = 3'((op - 4) % 8); w = 1; wz = 1; end
      else if (op == 12 && PILA) begin si = 0; pe = (stk.size() < DEPTH); end
      else if (op == 13 && PILA) begin si = 0; sp = 1; pe = (stk.size() > 0); end
      else if (op == 14) si = ~z;
      else if (op == 15) si = 0;
    end
    return {si, sm, w, wz, o, pe, sp};
  endfunction

  // {dir_ret, pila_vacia, pila_llena, error}
  function automatic logic [PCW+2:0] exp_flags();
    logic [PCW-1:0] top;
    top = (stk.size() > 0) ? stk[$] : '0;
    return {top, stk.size() == 0, stk.size() == DEPTH, m_err};
  endfunction

  function automatic logic [8:0] dut_ctrl();
    return {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.Op, bus.pc_en, bus.s_pila};
  endfunction

  function automatic logic [PCW+2:0] dut_flags();
    return {bus.dir_ret, bus.pila_vacia, bus.pila_llena, bus.error};
  endfunction

  task automatic apply(input int op, input logic z, input logic [PCW-1:0] pcn);
    logic [3:0] o4;
    o4 = 4'(op);
    cur_op = op; cur_z = z; cur_pc = pcn;
    bus.opcode  = {o4, 2'($urandom)};
    bus.zero    = z;
    bus.pc_next = pcn;
    #1;
  endtask

  task automatic tick();
    @(posedge reloj);
    model_edge(cur_op, cur_pc);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    apply(4, 1'b0, '0);
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic go_run();
    apply(4, 1'b0, '0);
    tick();
  endtask

  function automatic int rand_plain_op();
    int k;
    k = $urandom_range(0, 13);
    return (k < 12) ? k : k + 2;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    apply(9, 1'b1, 10'h3ff);
    checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
      $display("FAIL reset_low ctrl got=%b want=%b", dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
    checks++; if (dut_flags() !== exp_flags()) begin errors++;
      $display("FAIL reset_low flags got=%h want=%h", dut_flags(), exp_flags()); end
    tick();
    reset = 1'b1;
    apply(4, 1'b0, '0);
    checks++; if (bus.pc_en !== 1'b0) begin errors++;
      $display("FAIL arranque pc_en got=%b want=0", bus.pc_en); end
    tick();
    apply(4, 1'b0, '0);
    checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
      $display("FAIL first_ejec ctrl got=%b want=%b", dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 80; i++) begin
      apply((i < 12) ? i : rand_plain_op(), 1'($urandom), 10'($urandom));
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL decode op=%0d z=%b ctrl got=%b want=%b", cur_op, cur_z, dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      checks++; if (dut_flags() !== exp_flags()) begin errors++;
        $display("FAIL decode flags got=%h want=%h", dut_flags(), exp_flags()); end
      tick();
    end
  endtask

  task automatic test_call_ret();
    logic [PCW-1:0] dirs [4];
    dirs[0] = 10'h011; dirs[1] = 10'h022; dirs[2] = 10'h033; dirs[3] = 10'h044;
    do_reset(); go_run();
    for (int i = 0; i < 4; i++) begin
      apply(12, 1'b0, dirs[i]);
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL call%0d ctrl got=%b want=%b", i, dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      apply((i < 4) ? 13 : 4, 1'b0, '0);
      checks++; if (dut_flags() !== exp_flags()) begin errors++;
        $display("FAIL ret%0d flags got=%h want=%h", i, dut_flags(), exp_flags()); end
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL ret%0d ctrl got=%b want=%b", i, dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      tick();
    end
  endtask

  task automatic test_random_stack();
    do_reset(); go_run();
    for (int i = 0; i < 60; i++) begin
      int r, op;
      r = $urandom_range(0, 2);
      if (r == 0 && stk.size() < DEPTH) op = 12;
      else if (r == 1 && stk.size() > 0) op = 13;
      else op = rand_plain_op();
      apply(op, 1'($urandom), 10'($urandom));
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL rnd_stack op=%0d ctrl got=%b want=%b", cur_op, dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      checks++; if (dut_flags() !== exp_flags()) begin errors++;
        $display("FAIL rnd_stack flags got=%h want=%h", dut_flags(), exp_flags()); end
      tick();
    end
  endtask

  task automatic test_overflow();
    do_reset(); go_run();
    for (int i = 0; i < DEPTH + 1; i++) begin
      apply(12, 1'b0, 10'($urandom));
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL ovf_call%0d ctrl got=%b want=%b", i, dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      apply(rand_plain_op(), 1'($urandom), 10'($urandom));
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL ovf_hold ctrl got=%b want=%b", dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      checks++; if (dut_flags() !== exp_flags()) begin errors++;
        $display("FAIL ovf_hold flags got=%h want=%h", dut_flags(), exp_flags()); end
      tick();
    end
    do_reset();
    apply(4, 1'b0, '0);
    checks++; if (dut_flags() !== exp_flags()) begin errors++;
      $display("FAIL ovf_clear flags got=%h want=%h", dut_flags(), exp_flags()); end
  endtask

  task automatic test_underflow();
    do_reset(); go_run();
    apply(13, 1'b0, '0);
    checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
      $display("FAIL unf_ret ctrl got=%b want=%b", dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(rand_plain_op(), 1'($urandom), '0);
      checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
        $display("FAIL unf_hold ctrl got=%b want=%b", dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
      checks++; if (dut_flags() !== exp_flags()) begin errors++;
        $display("FAIL unf_hold flags got=%h want=%h", dut_flags(), exp_flags()); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); go_run();
    apply(12, 1'b0, 10'h155);
    #2;
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    apply(4, 1'b0, '0);
    checks++; if (dut_flags() !== exp_flags()) begin errors++;
      $display("FAIL rst_mid flags got=%h want=%h", dut_flags(), exp_flags()); end
    tick();
    apply(4, 1'b0, '0);
    checks++; if (dut_ctrl() !== exp_ctrl(cur_op, cur_z)) begin errors++;
      $display("FAIL rst_mid ctrl got=%b want=%b", dut_ctrl(), exp_ctrl(cur_op, cur_z)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.opcode = '0; bus.zero = 1'b0; bus.pc_next = '0;
    model_reset();
    cur_op = 0; cur_z = 1'b0; cur_pc = '0;
    #7;
    test_reset();
    test_decode();
    test_call_ret();
    test_random_stack();
    test_overflow();
    test_underflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unidad_control_pila.md
UNIDAD_CONTROL_PILA -- requirements
Module: unidad_control_pila

Interface
REQ-001 Parameter OPW, default 6, opcode width (>=4); decode uses opcode[OPW-1:OPW-4] ("op4").
REQ-002 Parameter PCW, default 10, program-counter/return-address width.
REQ-003 Parameter DEPTH, default 4, return-stack entries (>=1).
REQ-004 reloj  input  1  single clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 opcode  input  OPW  current instruction opcode.
REQ-007 zero  input  1  registered ALU zero flag.
REQ-008 pc_next  input  PCW  PC+1 of current instruction, pushed on call.
REQ-009 s_inc, s_inm, we3, wez  output  1 each  PC-increment select, immediate select, register-file write, zero-flag write.
REQ-010 Op  output  3  ALU operation.
REQ-011 pc_en  output  1  PC register load enable.
REQ-012 s_pila  output  1  PC source = dir_ret.
REQ-013 dir_ret  output  PCW  top-of-stack return address, 0 when empty.
REQ-014 pila_vacia, pila_llena, error  output  1 each  stack empty, stack full, sticky fault.

Function
REQ-015 FSM states: ARRANQUE, EJEC, PARADO; ARRANQUE->EJEC unconditionally on first rising edge after reset release.
REQ-016 ARRANQUE and PARADO: pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, s_pila=0, Op=000; no stack change.
REQ-017 EJEC: pc_en=1; decode combinational from op4 and zero, same cycle (zero latency).
REQ-018 op4 0000: s_inc=1, s_inm=1, Op=000, we3=1, wez=1.
REQ-019 op4 0001/0010/0011: s_inc=1, s_inm=1, Op=010/011/110, wez=1; we3=1 except 0010 (compare) we3=0.
REQ-020 op4 0100..1011: s_inc=1, s_inm=0, Op=(op4-4) mod 8, we3=1, wez=1.
REQ-021 op4 1100 (call): s_inc=0, we3=0, wez=0; pushes pc_next on the rising edge.
REQ-022 op4 1101 (ret): s_inc=0, s_pila=1, we3=0, wez=0; pops on the rising edge.
REQ-023 op4 1110 (jz): s_inc=~zero, we3=0, wez=0.
REQ-024 op4 1111 (jmp): s_inc=0, we3=0, wez=0.
REQ-025 Stack pointer sp counts 0..DEPTH; pila_vacia=(sp==0), pila_llena=(sp==DEPTH); dir_ret=entry[sp-1].
REQ-026 Call with sp==DEPTH: no push, no PC load (pc_en=0 that cycle), FSM->PARADO, error=1.
REQ-027 Ret with sp==0: no pop, pc_en=0 that cycle, FSM->PARADO, error=1.
REQ-028 error is sticky; PARADO exits only via reset.
REQ-029 Stack contents are not cleared by pop; only sp changes.

Reset
REQ-030 reset low asynchronously forces state=ARRANQUE, sp=0, error=0; all outputs then take ARRANQUE values, dir_ret=0.
REQ-031 Reset asserted mid-call/ret discards the pending push/pop.

Configuration
REQ-032 Macro UC_PILA_EN defined: call/ret/stack per REQ-021..029.
REQ-033 Macro UC_PILA_EN undefined: op4 1100/1101 decode as NOP (s_inc=1, we3=0, wez=0), no stack storage, s_pila=0, dir_ret=0, pila_vacia=1, pila_llena=0, error never set.

Verification
REQ-034 Reset low, then high; first edge -> pc_en 0 during ARRANQUE, 1 after; all outputs 0/ARRANQUE values while reset low.
REQ-035 Sweep op4 0000..1011 in EJEC -> Op/s_inm/we3/wez exactly per REQ-018..020 (e.g. 1010 -> Op=110, we3=1).
REQ-036 jz with zero=1 -> s_inc=0; zero=0 -> s_inc=1.
REQ-037 DEPTH=4: calls with pc_next 0x011,0x022,0x033,0x044 -> pila_llena=1; ret -> dir_ret=0x044, s_pila=1; ret x3 -> 0x033,0x022,0x011, pila_vacia=1.
REQ-038 Fifth call when full -> error=1, pc_en=0, PARADO held for 10 cycles, sp stays 4; reset clears.
REQ-039 Ret when empty -> error=1, PARADO; build without UC_PILA_EN -> same stimulus gives NOP, error=0.
